fpu_result: RTL and testbench
=============================

Name: fpu_result

Overview:
- Final pack/exception stage of the single-precision FPU datapath.
- Takes sign, biased exponent and fraction from the normalise/round stage, plus a 2-bit exception code.
- Registers one IEEE-754 binary32 word and a one-bit exception indicator for the FPU result bus.
- Purely combinational select/pack logic followed by one output register stage.

Parameters:
- None. Widths are fixed to binary32: 1 sign bit, 8 exponent bits, 23 fraction bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
- s  input  1  result sign.
- e  input  8  biased result exponent.
- m  input  23  result fraction, hidden bit excluded.
- flag_in  input  2  exception code from the upstream stage:
  - 00 normal
  - 01 overflow
  - 10 underflow
  - 11 invalid
- flag_out  output  1  registered exception indicator for the word on c.
- c  output  32  registered packed binary32 result.

Behaviour:
- Reset: on a rising clk edge with rst=0, c<=32'h0000_0000 and flag_out<=0. Reset takes priority over all inputs. Asserting reset in any cycle discards the word being computed.
- Latency: exactly 1 clock. Inputs sampled at edge N appear on c and flag_out after edge N, and hold until edge N+1. No handshake; a new word is accepted every cycle.
- flag_in=00 (normal):
  - c<={s,e,m}, with bit 31 = s, bits 30:23 = e, bits 22:0 = m.
  - flag_out<=1 only if e==8'hFF (input already encodes Inf or NaN); otherwise 0.
  - Subnormal inputs (e==0, m!=0) are handled as described under Optional Feature.
  - Zero (e==0, m==0) passes through with flag_out=0, sign preserved (±0).
- flag_in=01 (overflow): c<={s,8'hFF,23'h0} (signed infinity); flag_out<=1. e and m are ignored.
- flag_in=10 (underflow): c<={s,31'h0} (signed zero); flag_out<=1. e and m are ignored.
- flag_in=11 (invalid): c<=32'h7FC0_0000 (canonical quiet NaN, sign forced to 0); flag_out<=1. s, e and m are ignored.
- flag_in priority: the flag_in decode always wins over the operand contents.
- Width rules: no arithmetic is performed. Exponent and fraction are never modified except by the exception forcing above. No rounding in this block.
- Inputs changing mid-cycle have no effect until the next rising edge.

Optional Feature:
- Macro: RESULT_FTZ_EN.
- When defined (flush-to-zero): with flag_in=00, e==0 and m!=0, the block outputs c<={s,31'h0} and flag_out<=1.
- When not defined: subnormals pass through unchanged as {s,e,m} with flag_out<=0.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: hold rst=0 for 2 edges with s=1, e=8'h55, flag_in=01 -> c=32'h0000_0000, flag_out=0. Release rst=1 -> next edge c=32'hFF80_0000.
- Normal pack:
  - s=0, e=8'h02, m=23'h000001, flag_in=00 -> one edge later c=32'h0100_0001, flag_out=0.
  - Toggle s=1 -> c=32'h8100_0001.
  - e=8'h07, m=23'h050001, s=0 -> c=32'h0385_0001.
- Overflow and underflow:
  - flag_in=01, s=1, e=8'h07, m=23'h050001 -> c=32'hFF80_0000, flag_out=1.
  - flag_in=10, s=1 -> c=32'h8000_0000, flag_out=1.
- Invalid: flag_in=11, s=1, any e/m -> c=32'h7FC0_0000, flag_out=1. Then flag_in=00, s=0, e=8'hFF, m=0 -> c=32'h7F80_0000, flag_out=1.
- Subnormal: flag_in=00, s=0, e=8'h00, m=23'h000001:
  - without RESULT_FTZ_EN -> c=32'h0000_0001, flag_out=0.
  - with RESULT_FTZ_EN -> c=32'h0000_0000, flag_out=1.
- Back-to-back and latency: change flag_in every cycle through 00,01,10,11 with s=0, e=8'h02, m=1 -> c sequence 0100_0001, 7F80_0000, 0000_0000, 7FC0_0000, each exactly one edge after its input. Assert rst=0 mid-sequence -> the next edge gives c=0, flag_out=0.

Source files
------------

// File: rtl/fpu_result.sv
// Final pack/exception stage of the binary32 FPU: selects the packed word or a forced
// exception pattern and registers it. Optional flush-to-zero of subnormals: RESULT_FTZ_EN.
module fpu_result (
  input  logic        clk,
  input  logic        rst,
  input  logic        s,
  input  logic [7:0]  e,
  input  logic [22:0] m,
  input  logic [1:0]  flag_in,
  output logic        flag_out,
  output logic [31:0] c
);

  typedef enum logic [1:0] {
    FLAG_NORMAL    = 2'b00,
    FLAG_OVERFLOW  = 2'b01,
    FLAG_UNDERFLOW = 2'b10,
    FLAG_INVALID   = 2'b11
  } flag_code_e;

  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] QNAN_WORD = 32'h7FC0_0000;

  flag_code_e  flag_code;
  logic [31:0] c_next;
  logic        flag_next;

  assign flag_code = flag_code_e'(flag_in);

  always_comb begin
    // NOTE: both outputs get a default before the case so no path leaves them
    // unassigned, which would otherwise infer a latch.
    c_next    = {s, e, m};
    flag_next = (e == EXP_MAX);
    unique case (flag_code)
      FLAG_NORMAL: begin
`ifdef RESULT_FTZ_EN
        if (e == 8'h00 && m != 23'h0) begin
          c_next    = {s, 31'h0};
          flag_next = 1'b1;
        end
`endif
      end
      FLAG_OVERFLOW: begin
        c_next    = {s, EXP_MAX, 23'h0};
        flag_next = 1'b1;
      end
      FLAG_UNDERFLOW: begin
        c_next    = {s, 31'h0};
        flag_next = 1'b1;
      end
      FLAG_INVALID: begin
        // Canonical quiet NaN: the incoming sign is deliberately dropped.
        c_next    = QNAN_WORD;
        flag_next = 1'b1;
      end
      default: begin
        c_next    = {s, e, m};
        flag_next = (e == EXP_MAX);
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      c        <= 32'h0000_0000;
      flag_out <= 1'b0;
    end else begin
      c        <= c_next;
      flag_out <= flag_next;
    end
  end

endmodule

// File: tb/tb_fpu_result.sv
// Self-checking bench for fpu_result: driver pushes expected words into a scoreboard
// queue, an independent monitor pops and compares one edge later.
module tb_fpu_result;

  logic        clk;
  logic        rst;
  logic        s;
  logic [7:0]  e;
  logic [22:0] m;
  logic [1:0]  flag_in;
  logic        flag_out;
  logic [31:0] c;

  typedef struct {
    string       tag;
    logic [31:0] c;
    logic        flag;
  } expect_t;

  expect_t sb[$];
  int      checks_total  = 0;
  int      checks_passed = 0;

  fpu_result dut (
    .clk      (clk),
    .rst      (rst),
    .s        (s),
    .e        (e),
    .m        (m),
    .flag_in  (flag_in),
    .flag_out (flag_out),
    .c        (c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks_total++;
    if (actual === required) checks_passed++;
    else $display("FAIL %s: got %08h, expected %08h", name, actual, required);
  endtask

  // Reference model written from the IEEE-754 meaning of each exception code.
  function automatic expect_t model(input string tag, input logic rst_v, input logic sv,
                                    input logic [7:0] ev, input logic [22:0] mv,
                                    input logic [1:0] fv);
    expect_t r;
    logic subnormal;
    r.tag = tag;
    subnormal = (ev == 8'd0) && (mv != 23'd0);
    if (!rst_v) begin
      r.c = 32'h0; r.flag = 1'b0;
    end else if (fv == 2'd1) begin
      r.c = sv ? 32'hFF80_0000 : 32'h7F80_0000; r.flag = 1'b1;
    end else if (fv == 2'd2) begin
      r.c = sv ? 32'h8000_0000 : 32'h0000_0000; r.flag = 1'b1;
    end else if (fv == 2'd3) begin
      r.c = 32'h7FC0_0000; r.flag = 1'b1;
    end else begin
      r.c = (32'(sv) << 31) | (32'(ev) << 23) | 32'(mv);
      r.flag = (ev == 8'd255);
`ifdef RESULT_FTZ_EN
      if (subnormal) begin
        r.c = sv ? 32'h8000_0000 : 32'h0000_0000; r.flag = 1'b1;
      end
`endif
    end
    return r;
  endfunction

  task automatic drive(input string tag, input logic rst_v, input logic sv,
                       input logic [7:0] ev, input logic [22:0] mv, input logic [1:0] fv);
    @(negedge clk);
    rst = rst_v; s = sv; e = ev; m = mv; flag_in = fv;
    sb.push_back(model(tag, rst_v, sv, ev, mv, fv));
  endtask

  // Monitor: the DUT presents a new word every edge, compared #1 after it.
  always @(posedge clk) begin
    expect_t x;
    #1;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      check({x.tag, ".c"}, c, x.c);
      check({x.tag, ".flag"}, 32'(flag_out), 32'(x.flag));
    end
  end

  initial begin
    logic [7:0]  re;
    logic [22:0] rm;
    // Reset holds the output at zero despite an overflow request.
    drive("reset0", 1'b0, 1'b1, 8'h55, 23'h0, 2'b01);
    drive("reset1", 1'b0, 1'b1, 8'h55, 23'h0, 2'b01);
    drive("rel_ovf", 1'b1, 1'b1, 8'h55, 23'h0, 2'b01);
    // Normal packing.
    drive("pack_pos", 1'b1, 1'b0, 8'h02, 23'h000001, 2'b00);
    drive("pack_neg", 1'b1, 1'b1, 8'h02, 23'h000001, 2'b00);
    drive("pack_mix", 1'b1, 1'b0, 8'h07, 23'h050001, 2'b00);
    // Exceptions override operand contents.
    drive("ovf_neg", 1'b1, 1'b1, 8'h07, 23'h050001, 2'b01);
    drive("unf_neg", 1'b1, 1'b1, 8'h07, 23'h050001, 2'b10);
    drive("inv", 1'b1, 1'b1, 8'h3C, 23'h12345, 2'b11);
    drive("inf_in", 1'b1, 1'b0, 8'hFF, 23'h0, 2'b00);
    drive("nan_in", 1'b1, 1'b1, 8'hFF, 23'h400000, 2'b00);
    drive("subnorm", 1'b1, 1'b0, 8'h00, 23'h000001, 2'b00);
    drive("zero_neg", 1'b1, 1'b1, 8'h00, 23'h0, 2'b00);
    // Back-to-back flag sequence with a reset in the middle.
    for (int i = 0; i < 4; i++)
      drive($sformatf("seq%0d", i), 1'b1, 1'b0, 8'h02, 23'h1, 2'(i));
    drive("seq_n", 1'b1, 1'b0, 8'h02, 23'h1, 2'b00);
    drive("seq_o", 1'b1, 1'b0, 8'h02, 23'h1, 2'b01);
    drive("seq_rst", 1'b0, 1'b0, 8'h02, 23'h1, 2'b11);
    drive("seq_u", 1'b1, 1'b0, 8'h02, 23'h1, 2'b10);
    // Randomized traffic with corner exponents/fractions weighted in.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(3))
        0: re = 8'h00;
        1: re = 8'hFF;
        default: re = 8'($urandom);
      endcase
      rm = ($urandom_range(3) == 0) ? 23'h0 : 23'($urandom);
      drive($sformatf("rnd%0d", i), ($urandom_range(15) != 0), 1'($urandom), re, rm,
            2'($urandom_range(3)));
    end
    @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
